// File: rtl/smsdac_monitor.sv
// Segmented/mismatch-shaped DAC monitor: decodes the unit-element outputs, checks them
// against the delayed input code, and tracks per-pair switching-sequence running sums.
module smsdac_monitor #(
  parameter int LAT    = 1,
  parameter int SBOUND = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [4:0]  code_in,
  input  logic [7:0]  elem,
  output logic [4:0]  dac_v,
  output logic        match,
  output logic [7:0]  err_cnt,
  output logic [15:0] s_sum,
  output logic        bound_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK} state_t;

  localparam logic [1:0] FILL_LAST = 2'(LAT - 1);

  state_t     state;
  logic [1:0] fill_cnt;
  logic [4:0] value;
  logic [4:0] expected;
  logic       active;
  logic [3:0] over;
  logic [4:0] dly [LAT];

  // Each weight has two unit elements, so the sum tops out at 30 and fits 5 bits.
  always_comb begin
    value = ({1'b0, elem[7], 3'b000} + {1'b0, elem[6], 3'b000})
          + ({2'b00, elem[5], 2'b00} + {2'b00, elem[4], 2'b00})
          + ({3'b000, elem[3], 1'b0} + {3'b000, elem[2], 1'b0})
          + {4'b0000, elem[1]} + {4'b0000, elem[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dly[i] <= 5'd0;
    end else begin
      dly[0] <= code_in;
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign expected = dly[LAT-1];

  // Dropping en leaves CHECK on the same edge, so no comparison is made on that edge.
  assign active = en && (state == CHECK);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pair
      logic signed [4:0] step;
      logic signed [4:0] wide;
      logic signed [3:0] sat;
      logic signed [3:0] sum;

      assign step = $signed({4'b0000, elem[2*gi+1]}) - $signed({4'b0000, elem[2*gi]});
      assign wide = $signed({sum[3], sum}) + step;

      always_comb begin
        if (wide > 5'sd7)
          sat = 4'sd7;
        else if (wide < -5'sd8)
          sat = -4'sd8;
        else
          sat = wide[3:0];
      end

      assign over[gi] = active && ((int'(sat) > SBOUND) || (int'(sat) < -SBOUND));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          sum <= 4'sd0;
        else if (clr)
          sum <= 4'sd0;
        else if (active)
          sum <= sat;
      end

      assign s_sum[4*gi +: 4] = sum;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_cnt  <= 2'd0;
      busy      <= 1'b0;
      dac_v     <= 5'd0;
      match     <= 1'b0;
      err_cnt   <= 8'd0;
      bound_err <= 1'b0;
    end else begin
      dac_v <= value;

      if (!en) begin
        state    <= IDLE;
        busy     <= 1'b0;
        fill_cnt <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            state    <= FILL;
            busy     <= 1'b1;
            fill_cnt <= 2'd0;
          end
          FILL: begin
            busy <= 1'b1;
            if (fill_cnt == FILL_LAST)
              state <= CHECK;
            else
              fill_cnt <= fill_cnt + 2'd1;
          end
          CHECK: begin
            busy <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end

      // clr wins over any simultaneous check result; the FSM above is left alone.
      if (clr) begin
        match     <= 1'b0;
        err_cnt   <= 8'd0;
        bound_err <= 1'b0;
      end else if (active) begin
        match <= (value == expected);
        if ((value != expected) && (err_cnt != 8'hFF))
          err_cnt <= err_cnt + 8'd1;
        if (|over)
          bound_err <= 1'b1;
      end else begin
        match <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state != IDLE));
  a_match_only_check: assert property (@(posedge clk) disable iff (!rst_n)
    (state != CHECK) |-> !match);
`endif

endmodule
